// File: rtl/alu_unit_mc.sv
// ============================================================================
// alu_unit_mc : multi-cycle ALU; single-cycle ops plus radix-2 restoring DIV/MOD.
// Optional macro ALU_FLAGS_EN adds zero_o/carry_o.      Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module alu_unit_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [4:0]       oper_i,
    input  logic [WIDTH-1:0] a_data_i,
    input  logic [WIDTH-1:0] b_data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             div_zero_o
`ifdef ALU_FLAGS_EN
    ,
    output logic             zero_o,
    output logic             carry_o
`endif
);

    localparam int SHW   = $clog2(WIDTH);
    localparam int CNT_W = SHW + 1;

    localparam logic [4:0] OP_NOP = 5'd0;
    localparam logic [4:0] OP_ADD = 5'd1;
    localparam logic [4:0] OP_SUB = 5'd2;
    localparam logic [4:0] OP_MUL = 5'd3;
    localparam logic [4:0] OP_DIV = 5'd4;
    localparam logic [4:0] OP_MOD = 5'd5;
    localparam logic [4:0] OP_EQL = 5'd6;
    localparam logic [4:0] OP_GT  = 5'd7;
    localparam logic [4:0] OP_LT  = 5'd8;
    localparam logic [4:0] OP_SL  = 5'd9;
    localparam logic [4:0] OP_SR  = 5'd10;
    localparam logic [4:0] OP_SRA = 5'd11;
    localparam logic [4:0] OP_NOT = 5'd12;
    localparam logic [4:0] OP_AND = 5'd13;
    localparam logic [4:0] OP_OR  = 5'd14;
    localparam logic [4:0] OP_XOR = 5'd15;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_ready;
    logic               r_valid;
    logic               r_div_zero;
    logic [WIDTH-1:0]   r_data;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_divisor;
    logic               r_is_mod;
    logic [CNT_W-1:0]   r_count;

    logic               w_accept;
    logic               w_is_div;
    logic               w_b_zero;
    logic [SHW-1:0]     w_shamt;
    logic [WIDTH-1:0]   w_alu;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [WIDTH-1:0]   w_next_rem;
    logic [WIDTH-1:0]   w_next_quo;
    logic               w_load;
    logic               w_load_dz;
    logic [WIDTH-1:0]   w_load_val;

    assign w_accept = valid_i & r_ready;
    assign w_is_div = (oper_i == OP_DIV) || (oper_i == OP_MOD);
    assign w_b_zero = (b_data_i == '0);
    assign w_shamt  = b_data_i[SHW-1:0];

    always_comb begin
        w_alu = '0;
        case (oper_i)
            OP_NOP: w_alu = '0;
            OP_ADD: w_alu = a_data_i + b_data_i;
            OP_SUB: w_alu = a_data_i - b_data_i;
            OP_MUL: w_alu = a_data_i * b_data_i;
            OP_EQL: w_alu = {{(WIDTH-1){1'b0}}, (a_data_i == b_data_i)};
            OP_GT:  w_alu = {{(WIDTH-1){1'b0}}, (a_data_i >  b_data_i)};
            OP_LT:  w_alu = {{(WIDTH-1){1'b0}}, (a_data_i <  b_data_i)};
            OP_SL:  w_alu = a_data_i << w_shamt;
            OP_SR:  w_alu = a_data_i >> w_shamt;
            OP_SRA: w_alu = $unsigned($signed(a_data_i) >>> w_shamt);
            OP_NOT: w_alu = ~a_data_i;
            OP_AND: w_alu = a_data_i & b_data_i;
            OP_OR:  w_alu = a_data_i | b_data_i;
            OP_XOR: w_alu = a_data_i ^ b_data_i;
            default: w_alu = '0;
        endcase
    end

    // Partial remainder never exceeds 2*divisor-1, so the top bit of the
    // (WIDTH+1)-bit difference is a clean borrow flag.
    assign w_shift    = {r_rem, r_quo[WIDTH-1]};
    assign w_diff     = w_shift - {1'b0, r_divisor};
    assign w_ge       = ~w_diff[WIDTH];
    assign w_next_rem = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_next_quo = {r_quo[WIDTH-2:0], w_ge};

    always_comb begin
        w_load     = 1'b0;
        w_load_dz  = 1'b0;
        w_load_val = w_alu;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (!w_is_div) begin
                        w_load = 1'b1;
                    end else if (w_b_zero) begin
                        w_load     = 1'b1;
                        w_load_dz  = 1'b1;
                        w_load_val = (oper_i == OP_DIV) ? '1 : a_data_i;
                    end
                end
            end
            // Last iteration publishes its result directly; DONE is the valid cycle.
            S_DIV: begin
                if (r_count == CNT_W'(1)) begin
                    w_load     = 1'b1;
                    w_load_val = r_is_mod ? w_next_rem : w_next_quo;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_ready    <= 1'b1;
            r_valid    <= 1'b0;
            r_div_zero <= 1'b0;
            r_data     <= '0;
            r_quo      <= '0;
            r_rem      <= '0;
            r_divisor  <= '0;
            r_is_mod   <= 1'b0;
            r_count    <= '0;
        end else begin
            r_valid    <= w_load;
            r_div_zero <= w_load_dz;
            if (w_load) begin
                r_data <= w_load_val;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept && w_is_div && !w_b_zero) begin
                        r_quo     <= a_data_i;
                        r_divisor <= b_data_i;
                        r_rem     <= '0;
                        r_is_mod  <= (oper_i == OP_MOD);
                        r_count   <= CNT_W'(WIDTH);
                        r_ready   <= 1'b0;
                        r_state   <= S_DIV;
                    end
                end
                S_DIV: begin
                    r_rem   <= w_next_rem;
                    r_quo   <= w_next_quo;
                    r_count <= r_count - CNT_W'(1);
                    if (r_count == CNT_W'(1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready_o    = r_ready;
    assign valid_o    = r_valid;
    assign data_o     = r_data;
    assign div_zero_o = r_div_zero;

`ifdef ALU_FLAGS_EN
    logic w_carry;
    logic r_zero;
    logic r_carry;

    // ADD carries out exactly when the wrapped sum is smaller than an operand.
    always_comb begin
        w_carry = 1'b0;
        if (r_state == S_IDLE && !w_is_div) begin
            if (oper_i == OP_ADD) begin
                w_carry = (w_alu < a_data_i);
            end else if (oper_i == OP_SUB) begin
                w_carry = (a_data_i < b_data_i);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_zero  <= 1'b0;
            r_carry <= 1'b0;
        end else if (w_load) begin
            r_zero  <= (w_load_val == '0);
            r_carry <= w_carry;
        end
    end

    assign zero_o  = r_zero;
    assign carry_o = r_carry;
`endif

endmodule

`default_nettype wire
